upg_mem_arbiter: RTL and testbench

Arbitrates the instruction and data memories between the CPU core and the UART programmer, and sequences entry into and exit from programming mode. A debounced start button moves the system from RUN into LOAD. In LOAD the CPU is held in reset and the programmer owns both memory write ports. On programmer completion or idle timeout, the block releases the CPU through a short hold phase. It sits in `cpu_top` between `IFetch`/`memory` and the UART programmer core, replacing today's hard-wired `upg_*` connections.

---
 rtl/upg_pkg.sv | 18 +
 rtl/upg_mem_arbiter_btn_debounce.sv | 28 ++
 rtl/upg_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_upg_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// rtl/upg_pkg.sv - shared state encoding and memory-select constant for the programming arbiter
package upg_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ARM  = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } upg_state_e;

    // Programmer address bit that steers a write to data memory instead of instruction memory
    localparam int unsigned MEM_SEL_BIT = 14;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/upg_mem_arbiter_btn_debounce.sv
// rtl/upg_mem_arbiter_btn_debounce.sv - consecutive-high-sample button debouncer
module btn_debounce #(
    parameter int unsigned CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn,
    output logic pressed
);

    localparam int unsigned   CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    // pressed fires on the CYCLES-th consecutive high sample; the count holds there while held
    always_ff @(posedge clk) begin
        if (rst || !en || !btn) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pressed = en && btn && (cnt == LAST);

endmodule

// File: rtl/upg_mem_arbiter.sv
// rtl/upg_mem_arbiter.sv - memory port arbiter and RUN/ARM/LOAD/HOLD sequencer for UART programming
module upg_mem_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned UPG_RST_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1 << 24,
    parameter int unsigned CPU_HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic [31:0] upg_dat_i,
    input  logic        upg_done_i,
    input  logic [13:0] pc_adr,
    input  logic        cpu_wen,
    input  logic [13:0] cpu_adr,
    input  logic [31:0] cpu_dat,
    output logic        imem_wen,
    output logic        dmem_wen,
    output logic [13:0] imem_adr,
    output logic [13:0] dmem_adr,
    output logic [31:0] imem_dat,
    output logic [31:0] dmem_dat,
    output logic        cpu_rst,
    output logic        upg_rst,
    output logic        prog_mode,
    output logic        timeout_err,
    output logic [15:0] words_loaded
);

    import upg_pkg::*;

    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_ARM  = ST_ARM;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_HOLD = ST_HOLD;

    localparam int unsigned PMAX_A = (UPG_RST_CYCLES > CPU_HOLD_CYCLES) ? UPG_RST_CYCLES : CPU_HOLD_CYCLES;
    localparam int unsigned PMAX   = (TIMEOUT_CYCLES > PMAX_A) ? TIMEOUT_CYCLES : PMAX_A;
    localparam int unsigned PW     = $clog2(PMAX + 1);

    localparam logic [PW-1:0] ARM_LAST  = PW'(UPG_RST_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST = PW'(CPU_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] IDLE_LAST = PW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [15:0]   words_cnt;
    logic          terr;
    logic          press;
    logic          upg_wr;
    logic          idle_out;

    btn_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .en     (state == S_RUN),
        .btn    (start_btn),
        .pressed(press)
    );

    assign upg_wr   = (state == S_LOAD) && upg_wen_i && !rst;
    assign idle_out = !upg_wen_i && (phase_cnt == IDLE_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (press) state_nxt = S_ARM;
            S_ARM:   if (phase_cnt == ARM_LAST) state_nxt = S_LOAD;
            S_LOAD:  if (upg_done_i || idle_out) state_nxt = S_HOLD;
            S_HOLD:  if (phase_cnt == HOLD_LAST) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // phase_cnt times ARM and HOLD, and doubles as the idle counter in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            phase_cnt <= '0;
            words_cnt <= '0;
            terr      <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || upg_wr) begin
                phase_cnt <= '0;
            end else if (state != S_RUN) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if ((state == S_RUN) && press) begin
                words_cnt <= '0;
                terr      <= 1'b0;
            end else if (upg_wr) begin
                words_cnt <= sat_inc16(words_cnt);
            end
            if ((state == S_LOAD) && !upg_done_i && idle_out) begin
                terr <= 1'b1;
            end
        end
    end

    always_comb begin
        imem_wen = 1'b0;
        dmem_wen = 1'b0;
        imem_adr = pc_adr;
        imem_dat = upg_dat_i;
        dmem_adr = cpu_adr;
        dmem_dat = cpu_dat;
        case (state)
            S_RUN: begin
                dmem_wen = cpu_wen && !rst;
            end
            S_LOAD: begin
                imem_adr = upg_adr_i[13:0];
                dmem_adr = upg_adr_i[13:0];
                dmem_dat = upg_dat_i;
                imem_wen = upg_wr && !upg_adr_i[MEM_SEL_BIT];
                dmem_wen = upg_wr && upg_adr_i[MEM_SEL_BIT];
            end
            default: ;
        endcase
    end

    assign cpu_rst      = rst || (state != S_RUN);
    assign upg_rst      = !rst && (state == S_ARM);
    assign prog_mode    = (state != S_RUN);
    assign timeout_err  = terr;
    assign words_loaded = words_cnt;

endmodule

// File: tb/tb_upg_mem_arbiter.sv
// tb/tb_upg_mem_arbiter.sv - randomized scoreboard bench for upg_mem_arbiter
module tb_upg_mem_arbiter;

    localparam int unsigned DEB  = 200;
    localparam int unsigned URST = 4;
    localparam int unsigned TO   = 16;
    localparam int unsigned HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0;
    logic        upg_wen_i = 1'b0;
    logic [14:0] upg_adr_i = '0;
    logic [31:0] upg_dat_i = '0;
    logic        upg_done_i = 1'b0;
    logic [13:0] pc_adr = '0;
    logic        cpu_wen = 1'b0;
    logic [13:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic        imem_wen, dmem_wen;
    logic [13:0] imem_adr, dmem_adr;
    logic [31:0] imem_dat, dmem_dat;
    logic        cpu_rst, upg_rst, prog_mode, timeout_err;
    logic [15:0] words_loaded;

    upg_mem_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .UPG_RST_CYCLES (URST),
        .TIMEOUT_CYCLES (TO),
        .CPU_HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .upg_wen_i   (upg_wen_i),
        .upg_adr_i   (upg_adr_i),
        .upg_dat_i   (upg_dat_i),
        .upg_done_i  (upg_done_i),
        .pc_adr      (pc_adr),
        .cpu_wen     (cpu_wen),
        .cpu_adr     (cpu_adr),
        .cpu_dat     (cpu_dat),
        .imem_wen    (imem_wen),
        .dmem_wen    (dmem_wen),
        .imem_adr    (imem_adr),
        .dmem_adr    (dmem_adr),
        .imem_dat    (imem_dat),
        .dmem_dat    (dmem_dat),
        .cpu_rst     (cpu_rst),
        .upg_rst     (upg_rst),
        .prog_mode   (prog_mode),
        .timeout_err (timeout_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic        d;
        logic [13:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct packed {
        int          cyc;
        logic        prog;
        logic        crst;
        logic        urst;
        logic        terr;
        logic [15:0] words;
        logic        run;
    } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  errors = 0;
    int  checks = 0;

    logic [15:0] m_words = '0;
    logic        m_terr  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        pc_adr    = 14'($urandom);
        cpu_adr   = 14'($urandom);
        cpu_dat   = $urandom;
        upg_adr_i = 15'($urandom);
        upg_dat_i = $urandom;
    endtask

    task automatic push_wr(input logic d, input logic [13:0] adr, input logic [31:0] dat);
        wr_t w;
        w.cyc = cyc; w.d = d; w.adr = adr; w.dat = dat;
        wq.push_back(w);
    endtask

    task automatic exp_st(input logic prog, input logic crst, input logic urst, input logic run);
        st_t s;
        s.cyc = cyc; s.prog = prog; s.crst = crst; s.urst = urst;
        s.terr = m_terr; s.words = m_words; s.run = run;
        sq.push_back(s);
    endtask

    task automatic run_cycle(input logic btn);
        tick();
        rst = 1'b0;
        rand_bus();
        start_btn  = btn;
        cpu_wen    = 1'($urandom);
        upg_wen_i  = 1'($urandom);
        upg_done_i = 1'($urandom);
        if (cpu_wen) push_wr(1'b1, cpu_adr, cpu_dat);
        exp_st(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic blocked_cycle(input logic urst);
        tick();
        rand_bus();
        start_btn  = 1'($urandom);
        cpu_wen    = 1'($urandom);
        upg_wen_i  = 1'($urandom);
        upg_done_i = 1'($urandom);
        exp_st(1'b1, 1'b1, urst, 1'b0);
    endtask

    // kind: 0 = finish via done, 1 = idle timeout, 2 = reset mid-LOAD, 3 = directed two-word load
    task automatic session(input int kind);
        int   idle, n, nw, rst_at, c;
        logic fin, wr, done;
        repeat ($urandom_range(2, 6)) run_cycle(1'b0);
        for (int i = 0; i < int'(DEB); i++) run_cycle(1'b1);
        m_words = '0;
        m_terr  = 1'b0;
        repeat (URST) blocked_cycle(1'b1);
        idle = 0; n = 0; c = 0; fin = 1'b0;
        nw = $urandom_range(2, 8);
        rst_at = $urandom_range(1, 6);
        while (!fin && c < 500) begin
            tick();
            rand_bus();
            start_btn  = 1'($urandom);
            cpu_wen    = 1'($urandom);
            upg_wen_i  = 1'b0;
            upg_done_i = 1'b0;
            if (kind == 2 && c == rst_at) begin
                rst       = 1'b1;
                upg_wen_i = 1'b1;
                m_words   = '0;
                m_terr    = 1'b0;
                fin       = 1'b1;
            end else begin
                exp_st(1'b1, 1'b1, 1'b0, 1'b0);
                case (kind)
                    1:       wr = (n < nw) && 1'($urandom);
                    3:       wr = (c < 2);
                    default: wr = (idle >= 4) || 1'($urandom);
                endcase
                if (kind == 3) begin
                    upg_adr_i = (c == 0) ? 15'h0003 : 15'h4005;
                    upg_dat_i = 32'hDEADBEEF;
                end
                done = (kind == 0 && (n + int'(wr)) >= nw && (wr || 1'($urandom)))
                    || (kind == 3 && c == 1);
                upg_wen_i  = wr;
                upg_done_i = done;
                if (wr) begin
                    push_wr(upg_adr_i[14], upg_adr_i[13:0], upg_dat_i);
                    if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
                    n++;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (done) begin
                    fin = 1'b1;
                end else if (idle == int'(TO)) begin
                    m_terr = 1'b1;
                    fin    = 1'b1;
                end
            end
            c++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL load_bound kind=%0d got no session end after %0d cycles, want end", kind, c);
        end
        if (kind != 2) repeat (HOLD) blocked_cycle(1'b0);
    endtask

    wr_t         w_exp, w_got;
    st_t         s_exp;
    logic [20:0] s_got, s_want;
    logic        s_ok;

    always @(negedge clk) begin
        if (imem_wen && dmem_wen) begin
            checks++;
            errors++;
            $display("FAIL wr_both cyc=%0d got imem_wen=1 dmem_wen=1, want at most one", cyc);
        end else if (imem_wen || dmem_wen) begin
            checks++;
            w_got.cyc = cyc;
            w_got.d   = dmem_wen;
            w_got.adr = dmem_wen ? dmem_adr : imem_adr;
            w_got.dat = dmem_wen ? dmem_dat : imem_dat;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected cyc=%0d got d=%0b adr=%h dat=%h, want no write",
                         cyc, w_got.d, w_got.adr, w_got.dat);
            end else begin
                w_exp = wq.pop_front();
                if (w_got !== w_exp) begin
                    errors++;
                    $display("FAIL wr_data got cyc=%0d d=%0b adr=%h dat=%h, want cyc=%0d d=%0b adr=%h dat=%h",
                             w_got.cyc, w_got.d, w_got.adr, w_got.dat,
                             w_exp.cyc, w_exp.d, w_exp.adr, w_exp.dat);
                end
            end
        end
        while (wq.size() > 0 && wq[0].cyc <= cyc) begin
            w_exp = wq.pop_front();
            checks++;
            errors++;
            $display("FAIL wr_missing cyc=%0d got no write, want d=%0b adr=%h dat=%h",
                     w_exp.cyc, w_exp.d, w_exp.adr, w_exp.dat);
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s_exp = sq.pop_front();
            checks++;
            s_got  = {prog_mode, cpu_rst, upg_rst, timeout_err, words_loaded, 1'b0};
            s_want = {s_exp.prog, s_exp.crst, s_exp.urst, s_exp.terr, s_exp.words, 1'b0};
            s_ok   = (s_exp.cyc == cyc) && (s_got === s_want)
                  && (!s_exp.run || (imem_adr === pc_adr && imem_wen === 1'b0));
            if (!s_ok) begin
                errors++;
                $display("FAIL status cyc=%0d got prog=%b crst=%b urst=%b terr=%b words=%0d imem_adr=%h, want cyc=%0d prog=%b crst=%b urst=%b terr=%b words=%0d imem_adr=%s",
                         cyc, prog_mode, cpu_rst, upg_rst, timeout_err, words_loaded, imem_adr,
                         s_exp.cyc, s_exp.prog, s_exp.crst, s_exp.urst, s_exp.terr, s_exp.words,
                         s_exp.run ? "pc_adr" : "any");
            end
        end
    end

    initial begin
        rst     = 1'b1;
        cpu_wen = 1'b1;
        rand_bus();
        repeat (2) begin
            tick();
            exp_st(1'b0, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < int'(DEB) - 1; i++) run_cycle(1'b1);
        repeat (5) run_cycle(1'b0);
        session(3);
        session(0);
        session(1);
        session(2);
        session(0);
        session(1);
        session(2);
        session(0);
        repeat (5) run_cycle(1'b0);
        tick();
        cpu_wen   = 1'b0;
        upg_wen_i = 1'b0;
        tick();
        tick();
        checks++;
        if (wq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL leftovers got wq=%0d sq=%0d pending, want 0 0", wq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
